// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU control codes and alu_op encodings for the issue stage
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int IMM_W = 6;
  localparam int CNT_W = 16;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R = 2'b10;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decode-side instruction/forward inputs and ALU-side registered outputs; master drives, slave is the stage
interface alu_issue_stage_if import alu_pkg::*; ();
  logic in_valid, in_ready;
  logic [1:0] alu_op;
  logic [2:0] funct;
  logic use_imm;
  logic [IMM_W-1:0] imm;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic rd_wen;
  logic exmem_wen, memwb_wen;
  logic [REG_ADDR_W-1:0] exmem_addr, memwb_addr;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic flush;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [2:0] alu_control;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic out_rd_wen, illegal_op;
  logic [CNT_W-1:0] issue_count;
  modport master(
    output in_valid, alu_op, funct, use_imm, imm, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_addr, rd_wen, exmem_wen, exmem_addr, exmem_result, memwb_wen, memwb_addr,
           memwb_result, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd_addr, out_rd_wen,
           illegal_op, issue_count
  );
  modport slave(
    input  in_valid, alu_op, funct, use_imm, imm, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_addr, rd_wen, exmem_wen, exmem_addr, exmem_result, memwb_wen, memwb_addr,
           memwb_result, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd_addr, out_rd_wen,
           illegal_op, issue_count
  );
endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// fwd_mux: picks EX/MEM result, else MEM/WB result, else register data for one source register
module fwd_mux import alu_pkg::*; (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic exmem_wen,
  input  logic [REG_ADDR_W-1:0] exmem_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic memwb_wen,
  input  logic [REG_ADDR_W-1:0] memwb_addr,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] sel
);
  always_comb
    sel = (exmem_wen && exmem_addr == addr) ? exmem_result :
          (memwb_wen && memwb_addr == addr) ? memwb_result : data;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register producing forwarded ALU operands, decoded alu_control, valid/ready, flush and issue count
module alu_issue_stage import alu_pkg::*; (
  input logic clk,
  input logic rst_n,
  alu_issue_stage_if.slave bus
);
  logic [DATA_W-1:0] fwd_a, fwd_b, b_sel;
  logic [2:0] ctl;
  logic ill, accept;
  fwd_mux u_fwd_a (
    .addr(bus.rs1_addr), .data(bus.rs1_data),
    .exmem_wen(bus.exmem_wen), .exmem_addr(bus.exmem_addr), .exmem_result(bus.exmem_result),
    .memwb_wen(bus.memwb_wen), .memwb_addr(bus.memwb_addr), .memwb_result(bus.memwb_result),
    .sel(fwd_a)
  );
  fwd_mux u_fwd_b (
    .addr(bus.rs2_addr), .data(bus.rs2_data),
    .exmem_wen(bus.exmem_wen), .exmem_addr(bus.exmem_addr), .exmem_result(bus.exmem_result),
    .memwb_wen(bus.memwb_wen), .memwb_addr(bus.memwb_addr), .memwb_result(bus.memwb_result),
    .sel(fwd_b)
  );
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  always_comb begin
    accept = bus.in_valid && bus.in_ready && !bus.flush;
    ill = bus.alu_op == ALUOP_R ? !(bus.funct inside {ALU_ADD, ALU_SUB, ALU_SHL}) :
          !(bus.alu_op inside {ALUOP_MEM, ALUOP_BR});
    ctl = ill ? ALU_ADD : bus.alu_op == ALUOP_BR ? ALU_SUB : bus.alu_op == ALUOP_R ? bus.funct : ALU_ADD;
    b_sel = bus.use_imm ? {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : fwd_b;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_control <= '0;
      bus.out_rd_addr <= '0;
      bus.out_rd_wen <= 1'b0;
      bus.illegal_op <= 1'b0;
      bus.issue_count <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.alu_a <= fwd_a;
      bus.alu_b <= b_sel;
      bus.alu_control <= ctl;
      bus.out_rd_addr <= bus.rd_addr;
      bus.out_rd_wen <= bus.rd_wen;
      bus.illegal_op <= ill;
      bus.issue_count <= bus.issue_count + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table vectors, hand sequences and randomized traffic against a queue-based reference model
module tb_alu_issue_stage;
  import alu_pkg::*;
  typedef struct {
    logic [1:0] alu_op; logic [2:0] funct; logic use_imm; logic [5:0] imm;
    logic [2:0] rs1_addr, rs2_addr; logic [15:0] rs1_data, rs2_data;
    logic [2:0] rd_addr; logic rd_wen;
    logic ex_wen; logic [2:0] ex_addr; logic [15:0] ex_res;
    logic mw_wen; logic [2:0] mw_addr; logic [15:0] mw_res;
  } instr_t;
  typedef struct {
    logic [15:0] a, b; logic [2:0] ctl; logic ill; logic [2:0] rd; logic wen;
  } out_t;
  typedef struct { instr_t i; out_t o; } vec_t;
  logic clk = 0, rst_n = 0;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] cnt_m = 0;
  out_t q[$];
  instr_t cur, x1, x2;
  vec_t tv[8];
  alu_issue_stage_if bus();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] pick(logic [2:0] addr, logic [15:0] data, instr_t x);
    if (x.ex_wen && x.ex_addr == addr) return x.ex_res;
    if (x.mw_wen && x.mw_addr == addr) return x.mw_res;
    return data;
  endfunction
  function automatic out_t model(instr_t x);
    out_t o;
    o.a = pick(x.rs1_addr, x.rs1_data, x);
    o.b = x.use_imm ? {{10{x.imm[5]}}, x.imm} : pick(x.rs2_addr, x.rs2_data, x);
    o.rd = x.rd_addr;
    o.wen = x.rd_wen;
    o.ill = 0;
    case (x.alu_op)
      2'd0: o.ctl = 3'd0;
      2'd1: o.ctl = 3'd1;
      2'd2: if (x.funct == 0 || x.funct == 1 || x.funct == 3) o.ctl = x.funct;
            else begin o.ctl = 3'd0; o.ill = 1; end
      default: begin o.ctl = 3'd0; o.ill = 1; end
    endcase
    return o;
  endfunction
  function automatic instr_t blank();
    instr_t x;
    x = '{alu_op:0, funct:0, use_imm:0, imm:0, rs1_addr:0, rs2_addr:0, rs1_data:0, rs2_data:0,
          rd_addr:0, rd_wen:0, ex_wen:0, ex_addr:0, ex_res:0, mw_wen:0, mw_addr:0, mw_res:0};
    return x;
  endfunction
  function automatic instr_t rnd();
    instr_t x;
    x.alu_op = 2'($urandom); x.funct = 3'($urandom); x.use_imm = 1'($urandom); x.imm = 6'($urandom);
    x.rs1_addr = 3'($urandom_range(0, 3)); x.rs2_addr = 3'($urandom_range(0, 3));
    x.rs1_data = 16'($urandom); x.rs2_data = 16'($urandom);
    x.rd_addr = 3'($urandom); x.rd_wen = 1'($urandom);
    x.ex_wen = 1'($urandom); x.ex_addr = 3'($urandom_range(0, 3)); x.ex_res = 16'($urandom);
    x.mw_wen = 1'($urandom); x.mw_addr = 3'($urandom_range(0, 3)); x.mw_res = 16'($urandom);
    return x;
  endfunction
  task automatic drive(instr_t x, logic v, logic ordy, logic fl);
    cur = x;
    bus.alu_op = x.alu_op; bus.funct = x.funct; bus.use_imm = x.use_imm; bus.imm = x.imm;
    bus.rs1_addr = x.rs1_addr; bus.rs2_addr = x.rs2_addr; bus.rs1_data = x.rs1_data; bus.rs2_data = x.rs2_data;
    bus.rd_addr = x.rd_addr; bus.rd_wen = x.rd_wen;
    bus.exmem_wen = x.ex_wen; bus.exmem_addr = x.ex_addr; bus.exmem_result = x.ex_res;
    bus.memwb_wen = x.mw_wen; bus.memwb_addr = x.mw_addr; bus.memwb_result = x.mw_res;
    bus.in_valid = v; bus.out_ready = ordy; bus.flush = fl;
  endtask
  // One clock: the stage is modelled as a queue holding at most one issued instruction.
  task automatic tick();
    bit rdy;
    rdy = q.size() == 0 || bus.out_ready;
    #1 chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (bus.flush) q.delete();
    else begin
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy) begin q.push_back(model(cur)); cnt_m++; end
    end
    @(posedge clk); #1;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("issue_count", 32'(bus.issue_count), 32'(cnt_m));
    if (q.size() != 0) begin
      chk("alu_a", 32'(bus.alu_a), 32'(q[0].a));
      chk("alu_b", 32'(bus.alu_b), 32'(q[0].b));
      chk("alu_control", 32'(bus.alu_control), 32'(q[0].ctl));
      chk("illegal_op", 32'(bus.illegal_op), 32'(q[0].ill));
      chk("out_rd_addr", 32'(bus.out_rd_addr), 32'(q[0].rd));
      chk("out_rd_wen", 32'(bus.out_rd_wen), 32'(q[0].wen));
    end
  endtask
  task automatic do_reset();
    drive(rnd(), 1, 1, 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst issue_count", 32'(bus.issue_count), 0);
    chk("rst alu_a", 32'(bus.alu_a), 0);
    chk("rst alu_b", 32'(bus.alu_b), 0);
    chk("rst alu_control", 32'(bus.alu_control), 0);
    chk("rst rd", {29'd0, bus.out_rd_addr}, 0);
    chk("rst rd_wen/illegal", {30'd0, bus.out_rd_wen, bus.illegal_op}, 0);
    q.delete();
    cnt_m = 0;
    rst_n = 1;
  endtask
  initial begin
    instr_t b;
    b = blank();
    for (int k = 0; k < 8; k++) tv[k].i = b;
    tv[0].i.alu_op = 2; tv[0].i.funct = 3; tv[0].i.rs1_data = 16'h0003; tv[0].i.rs2_data = 16'h0002;
    tv[0].i.rd_addr = 5; tv[0].i.rd_wen = 1;
    tv[0].o = '{a:16'h0003, b:16'h0002, ctl:3'b011, ill:0, rd:5, wen:1};
    tv[1].i = tv[0].i; tv[1].i.funct = 5;
    tv[1].o = '{a:16'h0003, b:16'h0002, ctl:3'b000, ill:1, rd:5, wen:1};
    tv[2].i.rs1_addr = 2; tv[2].i.rs1_data = 16'h3333; tv[2].i.rs2_addr = 5; tv[2].i.rs2_data = 16'h0055;
    tv[2].i.ex_wen = 1; tv[2].i.ex_addr = 2; tv[2].i.ex_res = 16'h1111;
    tv[2].i.mw_wen = 1; tv[2].i.mw_addr = 2; tv[2].i.mw_res = 16'h2222; tv[2].i.rd_addr = 7;
    tv[2].o = '{a:16'h1111, b:16'h0055, ctl:3'b000, ill:0, rd:7, wen:0};
    tv[3].i = tv[2].i; tv[3].i.ex_wen = 0;
    tv[3].o = '{a:16'h2222, b:16'h0055, ctl:3'b000, ill:0, rd:7, wen:0};
    tv[4].i.alu_op = 1; tv[4].i.use_imm = 1; tv[4].i.imm = 6'b111110;
    tv[4].i.rs1_addr = 1; tv[4].i.rs1_data = 16'h0101; tv[4].i.rs2_addr = 4; tv[4].i.rs2_data = 16'h4444;
    tv[4].i.ex_wen = 1; tv[4].i.ex_addr = 4; tv[4].i.ex_res = 16'hABCD;
    tv[4].o = '{a:16'h0101, b:16'hFFFE, ctl:3'b001, ill:0, rd:0, wen:0};
    tv[5].i.alu_op = 3; tv[5].i.funct = 1; tv[5].i.rs1_data = 16'h00AA; tv[5].i.rs2_data = 16'h00BB;
    tv[5].o = '{a:16'h00AA, b:16'h00BB, ctl:3'b000, ill:1, rd:0, wen:0};
    tv[6].i.alu_op = 2; tv[6].i.funct = 1; tv[6].i.rs1_data = 16'h0F0F; tv[6].i.rs2_addr = 6;
    tv[6].i.rs2_data = 16'h6666; tv[6].i.ex_wen = 1; tv[6].i.ex_res = 16'h8001;
    tv[6].i.mw_wen = 1; tv[6].i.mw_addr = 6; tv[6].i.mw_res = 16'h7777;
    tv[6].o = '{a:16'h8001, b:16'h7777, ctl:3'b001, ill:0, rd:0, wen:0};
    tv[7].i.alu_op = 2; tv[7].i.use_imm = 1; tv[7].i.imm = 6'b011111; tv[7].i.rd_addr = 3; tv[7].i.rd_wen = 1;
    tv[7].o = '{a:16'h0000, b:16'h001F, ctl:3'b000, ill:0, rd:3, wen:1};
    drive(b, 1, 1, 0);
    do_reset();
    drive(tv[0].i, 1, 1, 0);
    tick();
    chk("first accept latency", 32'(bus.out_valid), 1);
    for (int k = 0; k < 8; k++) begin
      drive(tv[k].i, 1, 1, 0);
      tick();
      chk($sformatf("vec%0d a", k), 32'(bus.alu_a), 32'(tv[k].o.a));
      chk($sformatf("vec%0d b", k), 32'(bus.alu_b), 32'(tv[k].o.b));
      chk($sformatf("vec%0d ctl", k), 32'(bus.alu_control), 32'(tv[k].o.ctl));
      chk($sformatf("vec%0d ill", k), 32'(bus.illegal_op), 32'(tv[k].o.ill));
      chk($sformatf("vec%0d rd", k), {28'd0, bus.out_rd_wen, bus.out_rd_addr}, {28'd0, tv[k].o.wen, tv[k].o.rd});
    end
    x1 = tv[0].i; x2 = tv[4].i;
    drive(x1, 1, 1, 0);
    tick();
    drive(x2, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold in_ready", 32'(bus.in_ready), 0);
      chk("hold alu_a", 32'(bus.alu_a), 32'h0003);
      chk("hold count", 32'(bus.issue_count), 32'd10);
    end
    drive(x2, 1, 1, 0);
    tick();
    chk("replace alu_b", 32'(bus.alu_b), 32'hFFFE);
    chk("replace valid", 32'(bus.out_valid), 1);
    chk("replace count", 32'(bus.issue_count), 32'd11);
    drive(x1, 1, 0, 1);
    tick();
    chk("flush valid", 32'(bus.out_valid), 0);
    chk("flush count", 32'(bus.issue_count), 32'd11);
    drive(b, 0, 1, 0);
    tick();
    for (int k = 0; k < 400; k++) begin
      drive(rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick();
    end
    do_reset();
    drive(tv[7].i, 1, 1, 0);
    repeat (65535) tick();
    chk("count preload", 32'(bus.issue_count), 32'hFFFF);
    tick();
    chk("count wrap", 32'(bus.issue_count), 32'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX stage that sits directly upstream of the 16-bit ALU. It accepts one decoded instruction per handshake and produces the ALU's registered inputs: a, b and the 3-bit alu_control.
- Operand selection order: forwarding from EX/MEM first, then MEM/WB, then the register file; b can be replaced by a sign-extended immediate.
- Decodes the 2-bit alu_op and the R-type funct into alu_control.
- Provides valid/ready flow control, a flush, and an issue counter.

Parameters:
DATA_W, 16, operand and result width
REG_ADDR_W, 3, register index width (8 registers)
IMM_W, 6, immediate field width before sign extension
CNT_W, 16, issue counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept an instruction this cycle
alu_op  in  2  00 = add (ld/st address), 01 = sub (branch compare), 10 = R-type uses funct, 11 = reserved
funct  in  3  R-type function
use_imm  in  1  1: b = sext(imm)
imm  in  IMM_W  immediate field
rs1_addr, rs2_addr  in  REG_ADDR_W each  source register indices
rs1_data, rs2_data  in  DATA_W each  register file read data
rd_addr  in  REG_ADDR_W  destination register
rd_wen  in  1  instruction writes rd
exmem_wen, exmem_addr, exmem_result  in  1/REG_ADDR_W/DATA_W  EX/MEM forward source
memwb_wen, memwb_addr, memwb_result  in  1/REG_ADDR_W/DATA_W  MEM/WB forward source
flush  in  1  kill the held and incoming instruction
out_valid  out  1  ALU inputs are valid
out_ready  in  1  downstream consumes
alu_a, alu_b  out  DATA_W each  ALU operands
alu_control  out  3  ALU operation code
out_rd_addr  out  REG_ADDR_W  destination register, passed through
out_rd_wen  out  1  write enable, passed through
illegal_op  out  1  registered; issued instruction had an undefined op
issue_count  out  CNT_W  number of accepted instructions

Behaviour:
- Clock and reset: single clock domain; rst_n is sampled only on the clk rising edge, i.e. reset is synchronous and active-low.
- Reset values:
  - out_valid = 0 and issue_count = 0.
  - alu_a, alu_b, alu_control, out_rd_addr, out_rd_wen and illegal_op all reset to 0.
  - Reset asserted mid-stream drops the held instruction with no partial update.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; a single output register, no skid buffer).
  - Accept occurs when in_valid && in_ready && !flush. On accept, all outputs load on the next edge and out_valid = 1.
  - Output consumed without a new accept: out_valid -> 0.
  - Output held (out_valid && !out_ready): all outputs are stable.
- Latency: 1 cycle from accept to out_valid.
- Flush:
  - flush = 1 forces out_valid -> 0 on the next edge.
  - An incoming instruction in the same cycle is not accepted and issue_count does not increment.
  - flush takes priority over accept and over out_ready.
- Decode of alu_control:
  - alu_op 00 -> 000.
  - alu_op 01 -> 001.
  - alu_op 10 -> funct when funct is 000, 001 or 011.
  - Any other funct, or alu_op 11 -> alu_control = 000 and illegal_op = 1.
  - illegal_op is registered alongside the other outputs. The instruction still issues; it is not dropped.
- Forwarding, evaluated independently for a (rs1) and for b (rs2):
  - If exmem_wen && exmem_addr == rsX_addr, use exmem_result.
  - Else if memwb_wen && memwb_addr == rsX_addr, use memwb_result.
  - Else use rsX_data.
  - When both sources match, EX/MEM wins.
  - Register 0 gets no special treatment.
- Immediate: when use_imm = 1, alu_b = sign extension of imm to DATA_W. Forwarding on b is ignored in that case.
- Sampling: forward sources are sampled only in the accept cycle. A held output is not re-forwarded.
- issue_count: increments by 1 per accept and wraps from 0xFFFF to 0x0000.
- Simultaneous consume and accept in one cycle: the new instruction replaces the old one and out_valid stays 1.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SHL = 3'b011
  - ALUOP_MEM = 2'b00, ALUOP_BR = 2'b01, ALUOP_R = 2'b10
  - DATA_W and REG_ADDR_W
- One sub-module: fwd_mux. It takes an address, register data and the two forward sources, and returns the selected operand. It is instantiated twice.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, issue_count = 0, all outputs 0. After release, the first accept gives out_valid = 1 exactly 1 cycle later.
- R-type decode: alu_op = 10, funct = 011, rs1_data = 0x0003, rs2_data = 0x0002, no forwarding -> alu_control = 011, a = 0x0003, b = 0x0002, illegal_op = 0. With funct = 101 -> alu_control = 000, illegal_op = 1.
- Forwarding: rs1_addr = 2, both exmem_addr and memwb_addr = 2 with both write enables set, exmem_result = 0x1111, memwb_result = 0x2222, rs1_data = 0x3333 -> alu_a = 0x1111. With exmem_wen = 0 -> alu_a = 0x2222.
- Immediate: use_imm = 1, imm = 6'b111110, rs2 matches exmem -> alu_b = 0xFFFE.
- Backpressure: out_ready = 0 for 3 cycles -> in_ready = 0 and outputs stable. Then out_ready = 1 with in_valid = 1 -> the next instruction is loaded the same edge, out_valid stays 1, issue_count increments by exactly 1 per accept.
- Flush and wrap: flush = 1 together with in_valid = 1 -> out_valid = 0 next cycle and issue_count unchanged. Preload issue_count to 0xFFFF via accepts, then one more accept -> 0x0000.
